// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
// Bundles the ALU, load, decode-check and register-file write signals of the
// write-back arbiter.
//   slave  : arbiter side (takes ALU/load/check inputs, drives ready/busy/rf_*/count)
//   master : environment side (drives producers and decode checks)
interface writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_wsel;
  logic [31:0]   alu_wdat;
  logic          ld_issue;
  logic [4:0]    ld_issue_sel;
  logic          ld_valid;
  logic [4:0]    ld_wsel;
  logic [31:0]   ld_wdat;
  logic [4:0]    chk_sel1;
  logic [4:0]    chk_sel2;
  logic          busy1;
  logic          busy2;
  logic          rf_wen;
  logic [4:0]    rf_wsel;
  logic [31:0]   rf_wdat;
  logic [CW-1:0] count;

  modport slave (
    input  alu_valid, alu_wsel, alu_wdat,
    input  ld_issue, ld_issue_sel, ld_valid, ld_wsel, ld_wdat,
    input  chk_sel1, chk_sel2,
    output alu_ready, busy1, busy2, rf_wen, rf_wsel, rf_wdat, count
  );

  modport master (
    output alu_valid, alu_wsel, alu_wdat,
    output ld_issue, ld_issue_sel, ld_valid, ld_wsel, ld_wdat,
    output chk_sel1, chk_sel2,
    input  alu_ready, busy1, busy2, rf_wen, rf_wsel, rf_wdat, count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Owns the single register-file write port. Merges late load returns (highest
// priority) and in-order ALU results (queued in a DEPTH-entry FIFO when they
// lose arbitration) into one registered write per cycle. A 32-bit pending-load
// scoreboard plus FIFO/rf match logic gives decode a per-source busy flag.
// Ports:
//   CLK   - system clock, rising edge
//   nRST  - synchronous active-low reset
//   bus   - writeback_arbiter_if.slave (ALU/load/check inputs, rf_*/busy/ready/count)
// Configuration macro:
//   WB_ARB_BYPASS_EN - when defined, an accepted ALU result may go straight to
//                      rf_* if the FIFO is empty; otherwise every ALU result is
//                      queued first (minimum two-edge latency).
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input logic                CLK,
  input logic                nRST,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [4:0]    r_fifo_sel [DEPTH];
  logic [31:0]   r_fifo_dat [DEPTH];
  logic [DEPTH-1:0] r_fifo_vld;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pending;
  logic          r_rf_wen;
  logic [4:0]    r_rf_wsel;
  logic [31:0]   r_rf_wdat;

  logic          w_alu_ready;
  logic          w_alu_take;
  logic          w_ld_take;
  logic          w_fifo_empty;
  logic          w_pop;
  logic          w_direct;
  logic          w_push;
  logic [31:0]   w_pending_nxt;
  logic          w_busy1;
  logic          w_busy2;

  // Ready depends only on registered occupancy, so a same-edge pop never raises it.
  assign w_alu_ready  = (r_count < CW'(DEPTH));
  // Writes to register 0 are accepted/returned but never reach the write port.
  assign w_alu_take   = bus.alu_valid && w_alu_ready && (bus.alu_wsel != 5'd0);
  assign w_ld_take    = bus.ld_valid && (bus.ld_wsel != 5'd0);
  assign w_fifo_empty = (r_count == '0);
  assign w_pop        = !w_ld_take && !w_fifo_empty;
  // Direct path only with an empty FIFO keeps ALU results in acceptance order.
  assign w_direct     = BYPASS && !w_ld_take && w_fifo_empty && w_alu_take;
  assign w_push       = w_alu_take && !w_direct;

  // Clear on return first, then set on issue, so a same-register issue wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.ld_valid) w_pending_nxt[bus.ld_wsel] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_sel != 5'd0)) w_pending_nxt[bus.ld_issue_sel] = 1'b1;
  end

  always_comb begin
    w_busy1 = r_pending[bus.chk_sel1] || (r_rf_wen && (r_rf_wsel == bus.chk_sel1));
    w_busy2 = r_pending[bus.chk_sel2] || (r_rf_wen && (r_rf_wsel == bus.chk_sel2));
    for (int i = 0; i < DEPTH; i++) begin
      if (r_fifo_vld[i] && (r_fifo_sel[i] == bus.chk_sel1)) w_busy1 = 1'b1;
      if (r_fifo_vld[i] && (r_fifo_sel[i] == bus.chk_sel2)) w_busy2 = 1'b1;
    end
    if (bus.chk_sel1 == 5'd0) w_busy1 = 1'b0;
    if (bus.chk_sel2 == 5'd0) w_busy2 = 1'b0;
  end

  // FIFO payload needs no reset; validity is tracked by r_fifo_vld/r_count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_sel[r_wr_ptr] <= bus.alu_wsel;
      r_fifo_dat[r_wr_ptr] <= bus.alu_wdat;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_fifo_vld <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_wsel  <= '0;
      r_rf_wdat  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_rf_wen  <= w_ld_take || w_pop || w_direct;
      if (w_ld_take) begin
        r_rf_wsel <= bus.ld_wsel;
        r_rf_wdat <= bus.ld_wdat;
      end else if (w_pop) begin
        r_rf_wsel <= r_fifo_sel[r_rd_ptr];
        r_rf_wdat <= r_fifo_dat[r_rd_ptr];
      end else if (w_direct) begin
        r_rf_wsel <= bus.alu_wsel;
        r_rf_wdat <= bus.alu_wdat;
      end
      // Push and pop never target the same slot: pop needs count>0, push needs count<DEPTH.
      if (w_pop) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_fifo_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.busy1     = w_busy1;
  assign bus.busy2     = w_busy2;
  assign bus.rf_wen    = r_rf_wen;
  assign bus.rf_wsel   = r_rf_wsel;
  assign bus.rf_wdat   = r_rf_wdat;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic nrst;
  int   errors;
  int   checks;

  writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();
  writeback_arbiter #(.DEPTH(DEPTH)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of waiting ALU writes, pending-load bit set, write port.
  typedef struct { logic [4:0] sel; logic [31:0] dat; } wr_t;
  wr_t         mq[$];
  bit          mpend[32];
  logic        m_wen;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;

  function automatic bit m_busy(logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    if (mpend[c]) return 1'b1;
    foreach (mq[i]) if (mq[i].sel == c) return 1'b1;
    if (m_wen && (m_wsel == c)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    bus.alu_valid = 0; bus.alu_wsel = 0; bus.alu_wdat = 0;
    bus.ld_issue = 0; bus.ld_issue_sel = 0;
    bus.ld_valid = 0; bus.ld_wsel = 0; bus.ld_wdat = 0;
    bus.chk_sel1 = 0; bus.chk_sel2 = 0;
  endtask

  // Advance model and DUT by one rising edge; returns at the following falling edge.
  task automatic tick();
    bit  acc;
    bit  direct;
    wr_t w;
    acc = bus.alu_valid && (mq.size() < DEPTH);
    direct = 0;
    if (!nrst) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 0;
      m_wen = 0; m_wsel = 0; m_wdat = 0;
    end else begin
      m_wen = 0;
      if (bus.ld_valid && bus.ld_wsel != 0) begin
        m_wen = 1; m_wsel = bus.ld_wsel; m_wdat = bus.ld_wdat;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        m_wen = 1; m_wsel = w.sel; m_wdat = w.dat;
      end else if (BYPASS && acc && bus.alu_wsel != 0) begin
        m_wen = 1; m_wsel = bus.alu_wsel; m_wdat = bus.alu_wdat; direct = 1;
      end
      if (acc && bus.alu_wsel != 0 && !direct) mq.push_back('{sel: bus.alu_wsel, dat: bus.alu_wdat});
      if (bus.ld_valid) mpend[bus.ld_wsel] = 0;
      if (bus.ld_issue && bus.ld_issue_sel != 0) mpend[bus.ld_issue_sel] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1; set_idle();
    bus.ld_issue = 1; bus.ld_issue_sel = 7;
    bus.alu_valid = 1; bus.alu_wsel = 3; bus.alu_wdat = 32'h33;
    tick();
    set_idle();
    nrst = 0; bus.alu_valid = 1; bus.alu_wsel = 4; bus.alu_wdat = 32'h44;
    tick(); tick();
    bus.chk_sel1 = 7; bus.chk_sel2 = 3;
    #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", bus.rf_wen); end
    checks++; if (bus.rf_wsel !== 5'd0 || bus.rf_wdat !== 32'd0) begin errors++; $display("FAIL reset_wdata: got sel %0d dat %0h expected 0 0", bus.rf_wsel, bus.rf_wdat); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.alu_ready); end
    checks++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b%0b expected 00", bus.busy1, bus.busy2); end
    nrst = 1; set_idle();
    tick();
  endtask

  task automatic test_direct();
    set_idle();
    bus.alu_valid = 1; bus.alu_wsel = 5; bus.alu_wdat = 32'hDEADBEEF;
    tick();
    set_idle();
    if (BYPASS) begin
      checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd5 || bus.rf_wdat !== 32'hDEADBEEF) begin
        errors++; $display("FAIL direct_edge1: got wen %0b sel %0d dat %0h expected 1 5 deadbeef", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    end else begin
      checks++; if (bus.rf_wen !== 1'b0 || bus.count !== CW'(1)) begin
        errors++; $display("FAIL queued_edge1: got wen %0b count %0d expected 0 1", bus.rf_wen, bus.count); end
      tick();
      checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd5 || bus.rf_wdat !== 32'hDEADBEEF) begin
        errors++; $display("FAIL queued_edge2: got wen %0b sel %0d dat %0h expected 1 5 deadbeef", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    end
    tick();
    checks++; if (bus.rf_wen !== 1'b0 || bus.rf_wsel !== 5'd5 || bus.count !== CW'(0)) begin
      errors++; $display("FAIL direct_hold: got wen %0b sel %0d count %0d expected 0 5 0", bus.rf_wen, bus.rf_wsel, bus.count); end
  endtask

  task automatic test_fill();
    int  idx;
    bit  rdy;
    wr_t got[$];
    idx = 1;
    for (int c = 0; c < 20; c++) begin
      set_idle();
      bus.ld_valid = (c < 5); bus.ld_wsel = 5'(20 + c); bus.ld_wdat = 32'h5000 + c;
      bus.alu_valid = (idx <= 5); bus.alu_wsel = 5'(idx); bus.alu_wdat = 32'hA000_0000 + idx;
      #1 rdy = bus.alu_ready;
      checks++; if (rdy !== (mq.size() < DEPTH)) begin errors++; $display("FAIL fill_ready c=%0d: got %0b expected %0b", c, rdy, mq.size() < DEPTH); end
      tick();
      if (rdy && idx <= 5) idx++;
      if (c == 4) begin
        checks++; if (bus.count !== CW'(4) || bus.alu_ready !== 1'b0) begin
          errors++; $display("FAIL fill_full: got count %0d ready %0b expected 4 0", bus.count, bus.alu_ready); end
        checks++; if (idx != 5) begin errors++; $display("FAIL fill_stall: got next %0d expected 5", idx); end
      end
      checks++; if (bus.rf_wen !== m_wen || (m_wen && (bus.rf_wsel !== m_wsel || bus.rf_wdat !== m_wdat))) begin
        errors++; $display("FAIL fill_write c=%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", c, bus.rf_wen, bus.rf_wsel, bus.rf_wdat, m_wen, m_wsel, m_wdat); end
      if (bus.rf_wen && bus.rf_wsel < 5'd20) got.push_back('{sel: bus.rf_wsel, dat: bus.rf_wdat});
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL drain_count: got %0d writes expected 5", got.size()); end
    foreach (got[i]) begin
      checks++; if (got[i].sel !== 5'(i + 1) || got[i].dat !== 32'hA000_0000 + i + 1) begin
        errors++; $display("FAIL drain_order %0d: got %0d/%0h expected %0d/%0h", i, got[i].sel, got[i].dat, i + 1, 32'hA000_0000 + i + 1); end
    end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL drain_empty: got %0d expected 0", bus.count); end
  endtask

  task automatic test_scoreboard();
    set_idle(); bus.ld_issue = 1; bus.ld_issue_sel = 9;
    tick();
    set_idle(); bus.chk_sel1 = 9; #1;
    checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL sb_issue_busy: got %0b expected 1", bus.busy1); end
    bus.ld_valid = 1; bus.ld_wsel = 9; bus.ld_wdat = 32'h1234;
    tick();
    set_idle(); bus.chk_sel1 = 9; #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd9 || bus.rf_wdat !== 32'h1234) begin
      errors++; $display("FAIL sb_ld_write: got %0b/%0d/%0h expected 1/9/1234", bus.rf_wen, bus.rf_wsel, bus.rf_wdat); end
    checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_wen: got %0b expected 1", bus.busy1); end
    tick();
    bus.chk_sel1 = 9; #1;
    checks++; if (bus.busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_clear: got %0b expected 0", bus.busy1); end
    bus.ld_issue = 1; bus.ld_issue_sel = 9; bus.ld_valid = 1; bus.ld_wsel = 9; bus.ld_wdat = 32'h55;
    tick();
    set_idle(); tick();
    bus.chk_sel1 = 9; #1;
    checks++; if (bus.busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %0b expected 1", bus.busy1); end
    bus.ld_valid = 1; bus.ld_wsel = 9; bus.ld_wdat = 32'h66;
    tick(); set_idle(); tick();
  endtask

  task automatic test_reg0();
    logic [CW-1:0] c0;
    set_idle();
    c0 = bus.count;
    bus.alu_valid = 1; bus.alu_wsel = 0; bus.alu_wdat = 32'hFFFF;
    bus.ld_valid = 1; bus.ld_wsel = 0; bus.ld_wdat = 32'hEEEE;
    bus.ld_issue = 1; bus.ld_issue_sel = 0;
    tick();
    set_idle(); #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reg0_wen: got %0b expected 0", bus.rf_wen); end
    checks++; if (bus.count !== c0) begin errors++; $display("FAIL reg0_count: got %0d expected %0d", bus.count, c0); end
    checks++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin errors++; $display("FAIL reg0_busy: got %0b%0b expected 00", bus.busy1, bus.busy2); end
    tick();
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("FAIL reg0_late_wen: got %0b expected 0", bus.rf_wen); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      nrst = ($urandom_range(0, 79) != 0);
      bus.alu_valid = $urandom_range(0, 1); bus.alu_wsel = 5'($urandom_range(0, 7)); bus.alu_wdat = $urandom;
      bus.ld_issue = ($urandom_range(0, 3) == 0); bus.ld_issue_sel = 5'($urandom_range(0, 7));
      bus.ld_valid = ($urandom_range(0, 2) == 0); bus.ld_wsel = 5'($urandom_range(0, 7)); bus.ld_wdat = $urandom;
      bus.chk_sel1 = 5'($urandom_range(0, 7)); bus.chk_sel2 = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.alu_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_ready c=%0d: got %0b expected %0b", c, bus.alu_ready, mq.size() < DEPTH); end
      checks++; if (bus.busy1 !== m_busy(bus.chk_sel1) || bus.busy2 !== m_busy(bus.chk_sel2)) begin
        errors++; $display("FAIL rand_busy c=%0d: got %0b%0b expected %0b%0b", c, bus.busy1, bus.busy2, m_busy(bus.chk_sel1), m_busy(bus.chk_sel2)); end
      tick();
      checks++; if (bus.rf_wen !== m_wen || bus.rf_wsel !== m_wsel || bus.rf_wdat !== m_wdat) begin
        errors++; $display("FAIL rand_write c=%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", c, bus.rf_wen, bus.rf_wsel, bus.rf_wdat, m_wen, m_wsel, m_wdat); end
      checks++; if (bus.count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, bus.count, mq.size()); end
    end
    nrst = 1;
  endtask

  initial begin
    errors = 0; checks = 0;
    nrst = 0;
    m_wen = 0; m_wsel = 0; m_wdat = 0;
    set_idle();
    @(negedge clk);
    tick();
    test_reset();
    test_direct();
    test_fill();
    test_scoreboard();
    test_reg0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
